// File: rtl/hmm_pkg.sv
// Shared definitions for the Viterbi trellis storage (hmm_matrix).
// Holds the default geometry plus the cell and row types used by the
// storage array and the argmax helper.
package hmm_pkg;

    localparam int WORD_NUM_BIT = 8;
    localparam int POS_NUM_BIT  = 4;
    localparam int POS_NUM      = 11;
    localparam int WORD_NUM     = 50;
    localparam int P_SIZE       = 32;

    // One trellis cell: path probability plus the backpointer to the
    // previous word's tag.
    typedef struct packed {
        logic [P_SIZE-1:0]  p;
        logic [POS_NUM-1:0] bp;
    } cell_t;

    // One word row: a cell for every tag.
    typedef cell_t row_t [POS_NUM];

endpackage

// File: rtl/hmm_argmax.sv
// Combinational argmax over one trellis row. Unsigned compare on the
// probability field; on equal probabilities the lowest tag index wins.
module hmm_argmax
    import hmm_pkg::*;
(
    input  row_t                   row,
    output logic [POS_NUM_BIT-1:0] best_idx
);

    // Linear scan with a strict greater-than so earlier tags keep ties
    always_comb begin
        logic [P_SIZE-1:0] best_p;
        best_idx = '0;
        best_p   = row[0].p;
        for (int i = 1; i < POS_NUM; i++) begin
            if (row[i].p > best_p) begin
                best_p   = row[i].p;
                best_idx = POS_NUM_BIT'(i);
            end
        end
    end

endmodule

// File: rtl/hmm_matrix.sv
// Viterbi trellis storage for the POS tagger: one probability and one
// backpointer per (word, tag) cell, written cell by cell and read back a
// whole row at a time with one cycle of latency. Traceback reads report
// the best tag of the row and its backpointer.
// Optional feature macro: HMM_MATRIX_CHANGE_EN enables the in-place
// backpointer replacement path (change_enable / change_p_index /
// change_pre_addr); without it those inputs are ignored.
module hmm_matrix
    import hmm_pkg::*;
#(
    parameter int word_num_bit = WORD_NUM_BIT,
    parameter int POS_num_bit  = POS_NUM_BIT,
    parameter int POS_num      = POS_NUM,
    parameter int word_num     = WORD_NUM,
    parameter int p_size       = P_SIZE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [word_num_bit-1:0] key,
    input  logic [POS_num_bit-1:0]  POS,
    input  logic [p_size-1:0]       posibility,
    input  logic [POS_num-1:0]      pre_addr,
    input  logic                    RW_HMM_matrix,
    input  logic [POS_num-1:0]      change_pre_addr,
    input  logic [POS_num_bit-1:0]  change_p_index,
    input  logic                    change_enable,
    input  logic                    choose_output,
    output logic [p_size-1:0]       P0,
    output logic [p_size-1:0]       P1,
    output logic [p_size-1:0]       P2,
    output logic [p_size-1:0]       P3,
    output logic [p_size-1:0]       P4,
    output logic [p_size-1:0]       P5,
    output logic [p_size-1:0]       P6,
    output logic [p_size-1:0]       P7,
    output logic [p_size-1:0]       P8,
    output logic [p_size-1:0]       P9,
    output logic [p_size-1:0]       P10,
    output logic [POS_num-1:0]      pre_addr_out,
    output logic [POS_num_bit-1:0]  POS_out
);

    localparam int ROW_BITS = $clog2(word_num);
    localparam int COL_BITS = $clog2(POS_num);

    row_t                   mem [word_num];
    logic [p_size-1:0]      p_q [POS_num];

    logic                   key_ok;
    logic                   pos_ok;
    logic [ROW_BITS-1:0]    row_idx;
    logic [COL_BITS-1:0]    col_idx;
    row_t                   rd_row;
    logic [POS_num_bit-1:0] best_tag;
    logic [POS_num_bit-1:0] sel_tag;
    logic                   sel_ok;
    logic [POS_num-1:0]     sel_bp;

    // Out-of-range rows are redirected to row 0 only to keep the array
    // index legal; key_ok gates every use of that row.
    assign key_ok  = 32'(key) < word_num;
    assign pos_ok  = 32'(POS) < POS_num;
    assign row_idx = key_ok ? key[ROW_BITS-1:0] : '0;
    assign col_idx = POS[COL_BITS-1:0];
    assign rd_row  = mem[row_idx];

    hmm_argmax u_argmax (
        .row      (rd_row),
        .best_idx (best_tag)
    );

    // Traceback picks the best tag, a normal read uses the requested one
    assign sel_tag = choose_output ? best_tag : POS;
    assign sel_ok  = 32'(sel_tag) < POS_num;
    assign sel_bp  = sel_ok ? rd_row[sel_tag[COL_BITS-1:0]].bp : '0;

`ifdef HMM_MATRIX_CHANGE_EN
    logic                chg_ok;
    logic [COL_BITS-1:0] chg_idx;
    assign chg_ok  = key_ok && (32'(change_p_index) < POS_num);
    assign chg_idx = change_p_index[COL_BITS-1:0];
`else
    logic unused_change;
    assign unused_change = ^{change_enable, change_pre_addr, change_p_index};
`endif

    // Trellis storage: cell writes, and optionally backpointer replacement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < word_num; r++) begin
                for (int c = 0; c < POS_num; c++) begin
                    mem[r][c] <= '0;
                end
            end
        end else if (RW_HMM_matrix) begin
            if (key_ok && pos_ok) begin
                mem[row_idx][col_idx].p  <= posibility;
                mem[row_idx][col_idx].bp <= pre_addr;
            end
`ifdef HMM_MATRIX_CHANGE_EN
        end else if (change_enable && chg_ok) begin
            mem[row_idx][chg_idx].bp <= change_pre_addr;
`endif
        end
    end

    // Registered row readout; write cycles leave the outputs untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < POS_num; c++) begin
                p_q[c] <= '0;
            end
            POS_out      <= '0;
            pre_addr_out <= '0;
        end else if (!RW_HMM_matrix) begin
            for (int c = 0; c < POS_num; c++) begin
                p_q[c] <= key_ok ? rd_row[c].p : '0;
            end
            POS_out      <= key_ok ? sel_tag : '0;
            pre_addr_out <= key_ok ? sel_bp : '0;
        end
    end

    assign P0  = p_q[0];
    assign P1  = p_q[1];
    assign P2  = p_q[2];
    assign P3  = p_q[3];
    assign P4  = p_q[4];
    assign P5  = p_q[5];
    assign P6  = p_q[6];
    assign P7  = p_q[7];
    assign P8  = p_q[8];
    assign P9  = p_q[9];
    assign P10 = p_q[10];

endmodule

// File: tb/tb_hmm_matrix.sv
// Self-checking bench for hmm_matrix: a reference trellis model produces
// the expected readout for every cycle, queued when the stimulus is
// driven and compared one cycle later. Honors HMM_MATRIX_CHANGE_EN.
module tb_hmm_matrix;

    typedef struct {
        logic [10:0][31:0] p;
        logic [3:0]        pos;
        logic [10:0]       bp;
        string             tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  key;
    logic [3:0]  POS;
    logic [31:0] posibility;
    logic [10:0] pre_addr;
    logic        RW_HMM_matrix;
    logic [10:0] change_pre_addr;
    logic [3:0]  change_p_index;
    logic        change_enable;
    logic        choose_output;
    logic [31:0] P0, P1, P2, P3, P4, P5, P6, P7, P8, P9, P10;
    logic [10:0] pre_addr_out;
    logic [3:0]  POS_out;

    logic [10:0][31:0] obs_p;
    assign obs_p = {P10, P9, P8, P7, P6, P5, P4, P3, P2, P1, P0};

    logic [31:0] mp  [50][11];
    logic [10:0] mbp [50][11];
    exp_t        last;
    exp_t        sb [$];

    int vectors = 0;
    int errors  = 0;

    hmm_matrix dut (
        .clk             (clk),
        .reset           (reset),
        .key             (key),
        .POS             (POS),
        .posibility      (posibility),
        .pre_addr        (pre_addr),
        .RW_HMM_matrix   (RW_HMM_matrix),
        .change_pre_addr (change_pre_addr),
        .change_p_index  (change_p_index),
        .change_enable   (change_enable),
        .choose_output   (choose_output),
        .P0              (P0),
        .P1              (P1),
        .P2              (P2),
        .P3              (P3),
        .P4              (P4),
        .P5              (P5),
        .P6              (P6),
        .P7              (P7),
        .P8              (P8),
        .P9              (P9),
        .P10             (P10),
        .pre_addr_out    (pre_addr_out),
        .POS_out         (POS_out)
    );

    always #5 clk = ~clk;

    // Safety net so the run always terminates
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired obs=running exp=finished");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void clearModel();
        for (int r = 0; r < 50; r++) begin
            for (int c = 0; c < 11; c++) begin
                mp[r][c]  = '0;
                mbp[r][c] = '0;
            end
        end
        last.p   = '0;
        last.pos = '0;
        last.bp  = '0;
    endfunction

    function automatic exp_t modelRead(input logic [7:0] k, input logic [3:0] pos,
                                       input logic choose);
        exp_t e;
        int   best;
        e.p   = '0;
        e.pos = '0;
        e.bp  = '0;
        if (int'(k) < 50) begin
            for (int c = 0; c < 11; c++) e.p[c] = mp[k][c];
            if (choose) begin
                best = 0;
                for (int c = 1; c < 11; c++) if (mp[k][c] > mp[k][best]) best = c;
                e.pos = 4'(best);
                e.bp  = mbp[k][best];
            end else begin
                e.pos = pos;
                e.bp  = (int'(pos) < 11) ? mbp[k][pos] : '0;
            end
        end
        return e;
    endfunction

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            errors++;
            $error("[TB] FAIL scoreboard_empty obs=0 entries exp=1 entry");
            return;
        end
        e = sb.pop_front();
        vectors++;
        assert (obs_p === e.p) else begin
            errors++;
            $error("[TB] FAIL %s.P obs=%h exp=%h", e.tag, obs_p, e.p);
        end
        vectors++;
        assert (POS_out === e.pos) else begin
            errors++;
            $error("[TB] FAIL %s.POS_out obs=%0d exp=%0d", e.tag, POS_out, e.pos);
        end
        vectors++;
        assert (pre_addr_out === e.bp) else begin
            errors++;
            $error("[TB] FAIL %s.pre_addr_out obs=%0d exp=%0d", e.tag, pre_addr_out, e.bp);
        end
    endtask

    // One clock of stimulus: predict, drive, clock, compare
    task automatic applyStimulus(input logic rw, input logic [7:0] k, input logic [3:0] pos,
                                 input logic [31:0] p, input logic [10:0] bp,
                                 input logic ch_en, input logic [3:0] ch_idx,
                                 input logic [10:0] ch_bp, input logic choose,
                                 input string tag);
        exp_t e;
        key             = k;
        POS             = pos;
        posibility      = p;
        pre_addr        = bp;
        RW_HMM_matrix   = rw;
        change_enable   = ch_en;
        change_p_index  = ch_idx;
        change_pre_addr = ch_bp;
        choose_output   = choose;
        if (rw) begin
            e = last;
            if (int'(k) < 50 && int'(pos) < 11) begin
                mp[k][pos]  = p;
                mbp[k][pos] = bp;
            end
        end else begin
            e = modelRead(k, pos, choose);
`ifdef HMM_MATRIX_CHANGE_EN
            if (ch_en && int'(k) < 50 && int'(ch_idx) < 11) mbp[k][ch_idx] = ch_bp;
`endif
        end
        e.tag = tag;
        last  = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Asynchronous reset: outputs must clear without waiting for an edge
    task automatic applyReset(input string tag);
        exp_t z;
        reset = 1'b1;
        clearModel();
        z     = last;
        z.tag = {tag, "_async"};
        sb.push_back(z);
        #2;
        checkOutput();
        z.tag = {tag, "_held"};
        sb.push_back(z);
        @(posedge clk);
        #1;
        checkOutput();
        reset = 1'b0;
    endtask

    initial begin
        logic [10:0] bp_after;
        reset = 1'b0; key = '0; POS = '0; posibility = '0; pre_addr = '0;
        RW_HMM_matrix = 1'b0; change_pre_addr = '0; change_p_index = '0;
        change_enable = 1'b0; choose_output = 1'b0;
        clearModel();
        @(posedge clk);
        #1;

        applyReset("reset");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, "read_after_reset");

        applyStimulus(1, 1, 0, 123, 1, 0, 0, 0, 0, "wr_k1p0_a");
        applyStimulus(1, 1, 0, 321, 3, 0, 0, 0, 0, "wr_k1p0_b");
        applyStimulus(1, 1, 3, 124, 3, 0, 0, 0, 0, "wr_k1p3");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, "traceback_k1");
        applyStimulus(0, 1, 3, 0, 0, 0, 0, 0, 0, "normal_k1p3");

        applyStimulus(0, 1, 0, 0, 0, 1, 0, 7, 1, "change_read_old");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, "traceback_after_change");
`ifdef HMM_MATRIX_CHANGE_EN
        bp_after = 11'd7;
`else
        bp_after = 11'd3;
`endif
        vectors++;
        assert (last.bp === bp_after) else begin
            errors++;
            $error("[TB] FAIL change_model obs=%0d exp=%0d", last.bp, bp_after);
        end

        applyStimulus(1, 1, 5, 10, 2, 1, 0, 9, 0, "write_with_change");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, "change_ignored_on_write");

        applyStimulus(1, 2, 4, 500, 5, 0, 0, 0, 0, "wr_tie_p4");
        applyStimulus(1, 2, 9, 500, 6, 0, 0, 0, 0, "wr_tie_p9");
        applyStimulus(0, 2, 0, 0, 0, 0, 0, 0, 1, "traceback_tie");

        applyStimulus(1, 60, 0, 999, 4, 0, 0, 0, 0, "wr_key60");
        applyStimulus(1, 1, 12, 999, 4, 0, 0, 0, 0, "wr_pos12");
        applyStimulus(0, 60, 0, 0, 0, 1, 0, 5, 1, "read_key60");
        applyStimulus(0, 1, 0, 0, 0, 1, 12, 5, 1, "change_idx12");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, "k1_unchanged");

        applyStimulus(1, 49, 10, 32'hFFFF_FFFF, 11'h7FF, 0, 0, 0, 0, "wr_k49p10");
        applyStimulus(0, 49, 10, 0, 0, 0, 0, 0, 0, "normal_k49p10");
        applyStimulus(0, 49, 0, 0, 0, 0, 0, 0, 1, "traceback_k49");
        applyStimulus(0, 50, 0, 0, 0, 0, 0, 0, 0, "read_key50");

        for (int i = 0; i < 40; i++) begin
            logic [31:0] rp;
            rp = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 3) * 100);
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 51)),
                          4'($urandom_range(0, 10)), rp, 11'($urandom()),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)),
                          11'($urandom()), 1'($urandom_range(0, 1)), "random");
        end

        applyStimulus(1, 3, 2, 77, 1, 0, 0, 0, 0, "wr_before_reset");
        applyReset("reset_mid");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, "read_after_mid_reset");
        applyStimulus(0, 3, 2, 0, 0, 0, 0, 0, 0, "k3_cleared");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
